// File: rtl/a2_bus_master.sv
// Apple II-style bus master: 14-phase timing generator, DRAM address mux and CPU access sequencer.
// Build option A2_LONG_CYCLE_EN stretches every 65th CPU cycle to 16 clocks.
module a2_bus_master #(
    parameter logic [15:0] VIDBASE = 16'h0400
) (
    input  logic        C14M,
    input  logic        nRST,
    input  logic        req,
    input  logic        req_we,
    input  logic        req_aux,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        C7M,
    output logic        Q3,
    output logic        PHI0,
    output logic        PHI1,
    output logic        nPRAS,
    output logic        nPCAS,
    output logic        RnW,
    output logic        RnW80,
    output logic        nEN80,
    output logic        nC07X,
    output logic [7:0]  RA,
    input  logic [7:0]  MD_in,
    output logic [7:0]  MD_out,
    output logic        MD_oe
);

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_e;

    state_e      st_q, st_d;
    logic [3:0]  h_q, h_d;
    logic [15:0] v_q, v_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic        aux_q, aux_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        long_cyc;
    logic [3:0]  last_h;
    logic [3:0]  cap_h;
    logic        cyc_end;
    logic        phi0_w;
    logic        acc_ph0;
    logic        oe_w;
    logic        ra_lo;
    logic [15:0] ra_src;

`ifdef A2_LONG_CYCLE_EN
    logic [6:0]  cyc_q, cyc_d;

    // cycle index 64 of every 65 is the stretched one
    assign long_cyc = (cyc_q == 7'd64);

    always_comb begin
        cyc_d = cyc_q;
        if (cyc_end) begin
            cyc_d = long_cyc ? 7'd0 : cyc_q + 7'd1;
        end
    end

    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            cyc_q <= 7'd0;
        end else begin
            cyc_q <= cyc_d;
        end
    end
`else
    assign long_cyc = 1'b0;
`endif

    assign last_h  = long_cyc ? 4'd15 : 4'd13;
    assign cap_h   = long_cyc ? 4'd14 : 4'd12;
    assign cyc_end = (h_q == last_h);

    always_comb begin
        h_d     = cyc_end ? 4'd0 : h_q + 4'd1;
        v_d     = v_q;
        st_d    = st_q;
        addr_d  = addr_q;
        we_d    = we_q;
        aux_d   = aux_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (cyc_end) begin
            if (v_q == VIDBASE + 16'h03FF) begin
                v_d = VIDBASE;
            end else begin
                v_d = v_q + 16'd1;
            end
            st_d = req ? ST_ACCESS : ST_IDLE;
            if (req) begin
                addr_d  = req_addr;
                we_d    = req_we;
                aux_d   = req_aux;
                wdata_d = req_wdata;
            end
        end
        if (st_q == ST_ACCESS && !we_q && h_q == cap_h) begin
            rdata_d = MD_in;
        end
    end

    always_ff @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            st_q    <= ST_IDLE;
            h_q     <= 4'd0;
            v_q     <= VIDBASE;
            addr_q  <= 16'h0000;
            we_q    <= 1'b0;
            aux_q   <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
        end else begin
            st_q    <= st_d;
            h_q     <= h_d;
            v_q     <= v_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            aux_q   <= aux_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // all bus outputs decode straight from registered state
    always_comb begin
        phi0_w  = (h_q >= 4'd7);
        acc_ph0 = (st_q == ST_ACCESS) && phi0_w;
        oe_w    = (st_q == ST_ACCESS) && we_q && (h_q >= 4'd8);
        ra_lo   = (h_q <= 4'd3) || (h_q >= 4'd7 && h_q <= 4'd10);
        ra_src  = acc_ph0 ? addr_q : v_q;

        C7M    = ~h_q[0];
        PHI0   = phi0_w;
        PHI1   = ~phi0_w;
        Q3     = ra_lo;
        nPRAS  = ~((h_q >= 4'd2 && h_q <= 4'd6) || (h_q >= 4'd9));
        nPCAS  = ~((h_q >= 4'd4 && h_q <= 4'd6) || (h_q >= 4'd11));
        RA     = ra_lo ? ra_src[7:0] : ra_src[15:8];
        RnW    = ~(acc_ph0 && we_q);
        nEN80  = ~(acc_ph0 && aux_q);
        RnW80  = (acc_ph0 && aux_q) ? ~we_q : 1'b1;
        nC07X  = ~(acc_ph0 && addr_q[15:4] == 12'hC07);
        MD_oe  = oe_w;
        MD_out = oe_w ? wdata_q : 8'h00;
        ack    = (st_q == ST_ACCESS) && cyc_end;
        rdata  = rdata_q;
    end

endmodule

// File: tb/tb_a2_bus_master.sv
// Bench for a2_bus_master: cycle-level reference model, clock-by-clock monitor
// and directed/randomized scenario tasks.
module tb_a2_bus_master;

    localparam logic [15:0] VB = 16'h0400;

    logic        C14M = 1'b0;
    logic        nRST = 1'b1;
    logic        req = 1'b0;
    logic        req_we = 1'b0;
    logic        req_aux = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic [7:0]  MD_in = 8'h00;
    logic        ack;
    logic [7:0]  rdata;
    logic        C7M, Q3, PHI0, PHI1, nPRAS, nPCAS;
    logic        RnW, RnW80, nEN80, nC07X;
    logic [7:0]  RA;
    logic [7:0]  MD_out;
    logic        MD_oe;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    a2_bus_master #(.VIDBASE(VB)) dut (
        .C14M(C14M), .nRST(nRST),
        .req(req), .req_we(req_we), .req_aux(req_aux),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack), .rdata(rdata),
        .C7M(C7M), .Q3(Q3), .PHI0(PHI0), .PHI1(PHI1),
        .nPRAS(nPRAS), .nPCAS(nPCAS),
        .RnW(RnW), .RnW80(RnW80), .nEN80(nEN80), .nC07X(nC07X),
        .RA(RA), .MD_in(MD_in), .MD_out(MD_out), .MD_oe(MD_oe)
    );

    always #5 C14M = ~C14M;

    // reference model: phase in cycle, cycle number, refresh address, access
    int          mh = 0;
    int          mn = 0;
    logic [15:0] mv = VB;
    bit          macc = 1'b0;
    bit          mwe = 1'b0;
    bit          maux = 1'b0;
    logic [15:0] maddr = 16'h0000;
    logic [7:0]  mwd = 8'h00;
    logic [7:0]  mrd = 8'h00;

    function automatic bit m_long();
`ifdef A2_LONG_CYCLE_EN
        return (mn % 65) == 64;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int mlast();
        return m_long() ? 15 : 13;
    endfunction

    always @(posedge C14M or negedge nRST) begin
        if (!nRST) begin
            mh   <= 0;
            mn   <= 0;
            mv   <= VB;
            macc <= 1'b0;
            mrd  <= 8'h00;
        end else begin
            if (macc && !mwe && mh == mlast() - 1) mrd <= MD_in;
            if (mh == mlast()) begin
                mh   <= 0;
                mn   <= mn + 1;
                mv   <= VB + 16'((int'(mv - VB) + 1) % 1024);
                macc <= req;
                if (req) begin
                    mwe   <= req_we;
                    maux  <= req_aux;
                    maddr <= req_addr;
                    mwd   <= req_wdata;
                end
            end else begin
                mh <= mh + 1;
            end
        end
    end

    function automatic logic [35:0] exp_vec();
        int          h;
        int          last;
        bit          ap, q3, oe;
        logic [15:0] src;
        logic [7:0]  ra;
        logic [11:0] ctl;
        h    = mh;
        last = mlast();
        ap   = macc && h >= 7;
        q3   = (h <= 3) || (h >= 7 && h <= 10);
        oe   = macc && mwe && h >= 8;
        src  = ap ? maddr : mv;
        ra   = q3 ? src[7:0] : src[15:8];
        ctl  = {(h % 2) == 0, q3, h >= 7, h < 7,
                !((h >= 2 && h <= 6) || (h >= 9 && h <= last)),
                !((h >= 4 && h <= 6) || (h >= 11 && h <= last)),
                !(ap && mwe), (ap && maux) ? !mwe : 1'b1,
                !(ap && maux), !(ap && maddr[15:4] == 12'hC07),
                oe, macc && h == last};
        return {ctl, ra, mrd, oe ? mwd : 8'h00};
    endfunction

    always @(negedge C14M) begin
        logic [35:0] got;
        logic [35:0] ex;
        if (mon_en) begin
            got = {C7M, Q3, PHI0, PHI1, nPRAS, nPCAS, RnW, RnW80, nEN80,
                   nC07X, MD_oe, ack, RA, rdata, MD_oe ? MD_out : 8'h00};
            ex = exp_vec();
            checks++;
            if (got !== ex) begin
                failures++;
                $display("FAIL monitor t=%0t h=%0d got=%h expected=%h",
                         $time, mh, got, ex);
            end
        end
    end

    localparam logic [11:0] RST_CTL = 12'b1101_1111_1100;

    task automatic test_reset();
        logic [11:0] ctl;
        req = 1'b1;
        repeat (3) @(negedge C14M);
        ctl = {C7M, PHI1, PHI0, Q3, nPRAS, nPCAS, RnW, RnW80, nEN80, nC07X, MD_oe, ack};
        checks++;
        if (ctl !== RST_CTL) begin
            failures++;
            $display("FAIL reset_ctl got=%b expected=%b", ctl, RST_CTL);
        end
        checks++;
        if (rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_rdata got=%h expected=00", rdata);
        end
        checks++;
        if (RA !== VB[7:0]) begin
            failures++;
            $display("FAIL reset_ra got=%h expected=%h", RA, VB[7:0]);
        end
        req = 1'b0;
    endtask

    task automatic test_idle();
        logic [4:0]  got;
        logic [4:0]  ex;
        logic [15:0] vx;
        int          hh;
        nRST = 1'b1;
        for (int i = 0; i <= 28; i++) begin
            hh  = i % 14;
            got = {PHI0, PHI1, Q3, nPRAS, nPCAS};
            ex  = {hh >= 7, hh < 7, hh < 4 || (hh >= 7 && hh < 11),
                   !((hh >= 2 && hh < 7) || hh >= 9),
                   !((hh >= 4 && hh < 7) || hh >= 11)};
            checks++;
            if (got !== ex) begin
                failures++;
                $display("FAIL idle_wave i=%0d got=%b expected=%b", i, got, ex);
            end
            if (hh == 0 || hh == 4) begin
                vx = VB + 16'(i / 14);
                checks++;
                if (RA !== (hh == 0 ? vx[7:0] : vx[15:8])) begin
                    failures++;
                    $display("FAIL idle_v i=%0d got=%h v=%h", i, RA, vx);
                end
            end
            @(negedge C14M);
        end
    endtask

    task automatic test_aux_write();
        int         n, acks;
        logic [4:0] got;
        logic [4:0] ex;
        req = 1'b1; req_we = 1'b1; req_aux = 1'b1;
        req_addr = 16'h2345; req_wdata = 8'hA5;
        n = 0; acks = 0;
        while (acks == 0 && n < 60) begin
            @(negedge C14M);
            n++;
            if (macc && mh >= 7) begin
                got = {nEN80, RnW80, MD_oe, RA == (mh <= 10 ? 8'h45 : 8'h23),
                       MD_oe ? MD_out == 8'hA5 : 1'b1};
                ex  = {1'b0, 1'b0, mh >= 8, 1'b1, 1'b1};
                checks++;
                if (got !== ex) begin
                    failures++;
                    $display("FAIL aux_write h=%0d got=%b expected=%b", mh, got, ex);
                end
            end
            if (ack) begin
                acks++;
                req = 1'b0;
            end
        end
        repeat (20) begin
            @(negedge C14M);
            if (ack) acks++;
        end
        checks++;
        if (acks !== 1) begin
            failures++;
            $display("FAIL aux_write_acks got=%0d expected=1", acks);
        end
    endtask

    task automatic test_bank_select();
        int         n, acks;
        logic [3:0] got;
        req = 1'b1; req_we = 1'b1; req_aux = 1'b0;
        req_addr = 16'hC073; req_wdata = 8'h3F;
        n = 0; acks = 0;
        while (acks == 0 && n < 60) begin
            @(negedge C14M);
            n++;
            if (macc && mh >= 7) begin
                got = {nC07X, RnW, nEN80, RnW80};
                checks++;
                if (got !== 4'b0011) begin
                    failures++;
                    $display("FAIL bank_select h=%0d got=%b expected=0011", mh, got);
                end
            end
            if (ack) begin
                acks++;
                req = 1'b0;
            end
        end
        checks++;
        if (acks !== 1) begin
            failures++;
            $display("FAIL bank_select_ack got=%0d expected=1", acks);
        end
    endtask

    task automatic test_main_read();
        int n, acks;
        req = 1'b1; req_we = 1'b0; req_aux = 1'b0;
        req_addr = 16'h0800; MD_in = 8'h5A;
        n = 0; acks = 0;
        while (acks == 0 && n < 60) begin
            @(negedge C14M);
            n++;
            checks++;
            if (RnW !== 1'b1 || MD_oe !== 1'b0) begin
                failures++;
                $display("FAIL main_read_ctl got RnW=%b MD_oe=%b expected 1/0", RnW, MD_oe);
            end
            if (ack) begin
                acks++;
                req = 1'b0;
                checks++;
                if (rdata !== 8'h5A) begin
                    failures++;
                    $display("FAIL main_read_data got=%h expected=5a", rdata);
                end
            end
        end
        checks++;
        if (acks !== 1) begin
            failures++;
            $display("FAIL main_read_ack got=%0d expected=1", acks);
        end
    endtask

    task automatic test_back_to_back();
        int          n, acks, last_t;
        logic [11:0] ctl;
        req = 1'b1; req_we = 1'b0; req_aux = 1'b0;
        req_addr = 16'h1234; MD_in = 8'($urandom);
        n = 0; acks = 0; last_t = 0;
        while (acks < 3 && n < 100) begin
            @(negedge C14M);
            n++;
            if (ack) begin
                if (acks > 0) begin
                    checks++;
                    if (n - last_t !== mlast() + 1) begin
                        failures++;
                        $display("FAIL b2b_gap got=%0d expected=%0d", n - last_t, mlast() + 1);
                    end
                end
                acks++;
                last_t = n;
                if (acks == 3) req = 1'b0;
            end
        end
        checks++;
        if (acks !== 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d expected=3", acks);
        end
        repeat (5) @(negedge C14M);
        req = 1'b1;
        n = 0; acks = 0;
        while (acks == 0 && n < 60) begin
            @(negedge C14M);
            n++;
            if (ack) acks++;
        end
        repeat (9) @(negedge C14M);
        nRST = 1'b0;
        acks = 0;
        repeat (20) begin
            @(negedge C14M);
            if (ack) acks++;
        end
        checks++;
        if (acks !== 0) begin
            failures++;
            $display("FAIL b2b_reset_ack got=%0d expected=0", acks);
        end
        ctl = {C7M, PHI1, PHI0, Q3, nPRAS, nPCAS, RnW, RnW80, nEN80, nC07X, MD_oe, ack};
        checks++;
        if (ctl !== RST_CTL) begin
            failures++;
            $display("FAIL b2b_reset_ctl got=%b expected=%b", ctl, RST_CTL);
        end
        req = 1'b0;
        nRST = 1'b1;
    endtask

    task automatic test_random();
        int          n, acks;
        logic [15:0] a;
        logic [7:0]  md;
        for (int t = 0; t < 24; t++) begin
            repeat ($urandom_range(0, 20)) @(negedge C14M);
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a[15:4] = 12'hC07;
            md = 8'($urandom);
            req_we = 1'($urandom); req_aux = 1'($urandom);
            req_addr = a; req_wdata = 8'($urandom); MD_in = md;
            req = 1'b1;
            n = 0; acks = 0;
            while (acks == 0 && n < 60) begin
                @(negedge C14M);
                n++;
                if (ack) begin
                    acks++;
                    req = 1'b0;
                    if (!req_we) begin
                        checks++;
                        if (rdata !== md) begin
                            failures++;
                            $display("FAIL random_read got=%h expected=%h", rdata, md);
                        end
                    end
                end
            end
            checks++;
            if (acks !== 1) begin
                failures++;
                $display("FAIL random_ack t=%0d got=%0d expected=1", t, acks);
                req = 1'b0;
            end
        end
    endtask

    task automatic test_long_cycle();
        int  n, c14, c16, other;
        bit  prev;
        c14 = 0; c16 = 0; other = 0;
        n = 0;
        prev = PHI1;
        while (!(PHI1 && !prev) && n < 40) begin
            prev = PHI1;
            @(negedge C14M);
            n++;
        end
        for (int k = 0; k < 65; k++) begin
            n = 0;
            prev = PHI1;
            do begin
                prev = PHI1;
                @(negedge C14M);
                n++;
            end while (!(PHI1 && !prev) && n < 40);
            if (n == 14) c14++;
            else if (n == 16) c16++;
            else other++;
        end
        checks++;
`ifdef A2_LONG_CYCLE_EN
        if (c14 !== 64 || c16 !== 1 || other !== 0) begin
            failures++;
            $display("FAIL long_cycle got 14:%0d 16:%0d other:%0d expected 64/1/0", c14, c16, other);
        end
`else
        if (c14 !== 65 || c16 !== 0 || other !== 0) begin
            failures++;
            $display("FAIL long_cycle got 14:%0d 16:%0d other:%0d expected 65/0/0", c14, c16, other);
        end
`endif
    endtask

    initial begin
        #2 nRST = 1'b0;
        #1 mon_en = 1'b1;
        test_reset();
        test_idle();
        test_aux_write();
        test_bank_select();
        test_main_read();
        test_back_to_back();
        test_random();
        test_long_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/a2_bus_master.md
A2_BUS_MASTER -- requirements
Module: a2_bus_master

Interface
REQ-001 SHALL have parameter VIDBASE, default 16'h0400, base address of the idle-phase video refresh counter.
REQ-002 SHALL have port C14M, input, 1, sole clock (14.318 MHz master).
REQ-003 SHALL have port nRST, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have request ports req (in 1), req_we (in 1), req_aux (in 1), req_addr (in 16), req_wdata (in 8): one CPU access request, held until ack.
REQ-005 SHALL have response ports ack (out 1, one-clock pulse) and rdata (out 8, read data).
REQ-006 SHALL have bus timing outputs C7M, Q3, PHI0, PHI1, nPRAS, nPCAS (out 1 each).
REQ-007 SHALL have bus control outputs RnW, RnW80, nEN80, nC07X (out 1 each) and RA (out 8, multiplexed DRAM address).
REQ-008 SHALL have data ports MD_in (in 8), MD_out (out 8), MD_oe (out 1, drive enable for MD).

Function
REQ-009 SHALL run phase counter H, 0..13 then wrap to 0; one CPU cycle is 14 C14M cycles.
REQ-010 SHALL toggle C7M every C14M edge; C7M high when H even.
REQ-011 SHALL drive PHI1=1 for H 0..6 and PHI0=1 for H 7..13; PHI0 = !PHI1 at all times.
REQ-012 SHALL drive Q3=1 for H 0..3 and 7..10, else 0.
REQ-013 SHALL drive nPRAS=0 for H 2..6 and 9..13; nPCAS=0 for H 4..6 and 11..13; both 1 otherwise.
REQ-014 SHALL drive RA during PHI1 as video counter V[7:0] for H 0..3 and V[15:8] for H 4..6.
REQ-015 SHALL drive RA during PHI0 as the access address [7:0] for H 7..10 and [15:8] for H 11..13; idle PHI0 uses V.
REQ-016 SHALL increment V by 1 at H==13 each cycle; V wraps from VIDBASE+16'h03FF back to VIDBASE.
REQ-017 SHALL sample req at H==13; if req=1, latch req_* and perform the access in the next PHI0; else next PHI0 is idle.
REQ-018 SHALL, during an access PHI0, drive RnW = !we; nEN80=0 iff aux; RnW80 = RnW if aux else 1.
REQ-019 SHALL drive nC07X=0 during access PHI0 iff addr[15:4]==12'hC07, regardless of aux.
REQ-020 SHALL, on write access, drive MD_out=wdata and MD_oe=1 for H 8..13; MD_oe=0 at all other times.
REQ-021 SHALL, on read access, capture rdata <= MD_in at H==12; rdata holds until the next read.
REQ-022 SHALL pulse ack=1 for exactly the H==13 clock of the access cycle.
REQ-023 SHALL, when req is still 1 at the same H==13 that ack pulses, treat it as a new request; back-to-back accesses occur in consecutive cycles.
REQ-024 SHALL keep idle cycles at RnW=1, RnW80=1, nEN80=1, nC07X=1, MD_oe=0.

Reset
REQ-025 SHALL on nRST=0 set H=0, V=VIDBASE, no access pending.
REQ-026 SHALL hold these outputs during reset: C7M=1, PHI1=1, PHI0=0, Q3=1, nPRAS=1, nPCAS=1, RnW=1, RnW80=1, nEN80=1, nC07X=1, MD_oe=0, ack=0, rdata=0, RA=VIDBASE[7:0].
REQ-027 SHALL abort any in-flight access on reset without issuing ack; the first cycle after release starts at H=0.

Configuration
REQ-028 SHALL support macro A2_LONG_CYCLE_EN.
- Defined: every 65th CPU cycle is stretched; H runs 0..15 with PHI0 held for H 7..15.
- Stretched cycle: nPCAS and nPRAS timing extends by 2 clocks.
- Stretched cycle: ack at H==15 and capture at H==14.
- Undefined: all cycles are 14 clocks.

Verification
REQ-029 SHALL check idle run: after reset release, 28 clocks give PHI0/PHI1/Q3/nPRAS/nPCAS waveforms per REQ-011..013, and V advances VIDBASE to VIDBASE+2.
REQ-030 SHALL check aux write: req_we=1, req_aux=1, addr 16'h2345, wdata 8'hA5 -> nEN80=0 and RnW80=0 for H 7..13; RA=8'h45 then 8'h23; MD_out=A5 with MD_oe=1 for H 8..13; single ack.
REQ-031 SHALL check bank select: write 8'h3F to 16'hC073 with req_aux=0 -> nC07X=0 and RnW=0 for H 7..13, nEN80=1, RnW80=1.
REQ-032 SHALL check main read: addr 16'h0800, MD_in=8'h5A stable during PHI0 -> rdata=8'h5A at ack; RnW=1 and MD_oe=0 throughout.
REQ-033 SHALL check back-to-back: req held high for 3 accesses -> acks exactly 14 clocks apart; assert nRST mid-second access -> no second ack, outputs at reset values.
REQ-034 SHALL check, with A2_LONG_CYCLE_EN defined, 65 idle cycles -> one cycle of 16 clocks and the others of 14 clocks.
